// File: rtl/mbist_march_ctrl.sv
// Purpose : March C- memory BIST controller that drives write_read/address/wdata, checks rdata and logs the first failure plus a saturating failure count.
// Latency : first op one cycle after start; each read is checked two cycles after issue; done follows the last op after a 2-cycle drain.
// Backpressure: none. The sequence runs at one op per cycle, and start is ignored while busy.
// Ports   : clk/rst_n (sync, active-low) | start | write_read, address, wdata -> memory | rdata <- memory
//           busy, done | fail, fail_elem, fail_addr, fail_data, fail_cnt (first-failure log + count)
module mbist_march_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    CAPACITY   = 16,
  parameter logic [DATA_WIDTH-1:0] DATA_BG    = '0,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [CNT_WIDTH-1:0]  fail_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [DATA_WIDTH-1:0] BG0       = DATA_BG;
  localparam logic [DATA_WIDTH-1:0] BG1       = ~DATA_BG;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   phase_q, phase_d;     // 0 = first op at this address, 1 = second
  logic                   drain_q, drain_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  // Two-stage check pipeline that travels alongside each read
  logic                   p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
  logic [DATA_WIDTH-1:0]  p1_exp_q, p1_exp_d, p2_exp_q, p2_exp_d;
  logic [2:0]             p1_elem_q, p1_elem_d, p2_elem_q, p2_elem_d;
  logic [ADDR_WIDTH-1:0]  p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;

  logic                   fail_q, fail_d;
  logic [2:0]             fail_elem_q, fail_elem_d;
  logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]  fail_data_q, fail_data_d;
  logic [CNT_WIDTH-1:0]   fail_cnt_q, fail_cnt_d;

  logic                   elem_down, two_op, last_addr, op_write, mis;
  logic [DATA_WIDTH-1:0]  elem_wdat, elem_exp;

  always_comb begin
    // M3/M4 walk downward; M1..M4 do a read then a write at each address
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    two_op    = (elem_q != 3'd0) && (elem_q != 3'd5);
    last_addr = elem_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    op_write  = (elem_q == 3'd0) || phase_q;
    elem_wdat = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? BG1 : BG0;
    elem_exp  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? BG1 : BG0;
    mis       = p2_vld_q && (rdata != p2_exp_q);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    drain_d     = drain_q;
    wdata_d     = wdata_q;
    write_read  = 1'b0;
    address     = '0;
    busy        = 1'b0;
    done        = 1'b0;
    p1_vld_d    = 1'b0;
    p1_exp_d    = elem_exp;
    p1_elem_d   = elem_q;
    p1_addr_d   = addr_q;
    p2_vld_d    = p1_vld_q;
    p2_exp_d    = p1_exp_q;
    p2_elem_d   = p1_elem_q;
    p2_addr_d   = p1_addr_q;
    fail_d      = fail_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_cnt_d  = fail_cnt_q;

    if (mis) begin
      fail_d = 1'b1;
      if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
      if (!fail_q) begin
        fail_elem_d = p2_elem_q;
        fail_addr_d = p2_addr_q;
        fail_data_d = rdata ^ p2_exp_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        done    = (state_q == S_DONE);
        wdata_d = BG0;   // first M0 write uses the background
        if (start) begin
          state_d     = S_RUN;
          elem_d      = '0;
          addr_d      = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_cnt_d  = '0;
        end
      end
      S_RUN: begin
        busy       = 1'b1;
        write_read = op_write;
        address    = addr_q;
        p1_vld_d   = !op_write;
        drain_d    = 1'b0;
        // wdata presents the data of the next op when it is a write,
        // otherwise it holds its current value.
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
          wdata_d = elem_wdat;
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = elem_down ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
            if (elem_q == 3'd0) wdata_d = BG0;
          end else if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
          end else begin
            // Every element starts with a read, so wdata holds here
            elem_d = elem_q + 3'd1;
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
          end
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      drain_q     <= 1'b0;
      wdata_q     <= BG0;
      p1_vld_q    <= 1'b0;
      p1_exp_q    <= '0;
      p1_elem_q   <= '0;
      p1_addr_q   <= '0;
      p2_vld_q    <= 1'b0;
      p2_exp_q    <= '0;
      p2_elem_q   <= '0;
      p2_addr_q   <= '0;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      wdata_q     <= wdata_d;
      p1_vld_q    <= p1_vld_d;
      p1_exp_q    <= p1_exp_d;
      p1_elem_q   <= p1_elem_d;
      p1_addr_q   <= p1_addr_d;
      p2_vld_q    <= p2_vld_d;
      p2_exp_q    <= p2_exp_d;
      p2_elem_q   <= p2_elem_d;
      p2_addr_q   <= p2_addr_d;
      fail_q      <= fail_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign wdata     = wdata_d;
  assign fail      = fail_q;
  assign fail_elem = fail_elem_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- test controller driving the `fault_mem` memory model's `write_read`/`address`/`wdata` port and checking its `rdata` return. It generates the full March C- sequence over a configurable address range and compares every read against the expected background. It records the first failure and a saturating failure count. It sits directly upstream of the memory under test in the MBIST datapath.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 4, memory address width
- CAPACITY, 16, words tested (N); addresses 0..N-1; N ≥ 2, N ≤ 2^ADDR_WIDTH
- DATA_BG, 0, data background: "0" = DATA_BG, "1" = ~DATA_BG
- CNT_WIDTH, 8, fail counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin test; sampled in IDLE or DONE only
- write_read  out  1  1 = write, 0 = read (to memory)
- address  out  ADDR_WIDTH  memory address
- wdata  out  DATA_WIDTH  write data, leads its write by one cycle
- rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in RUN and DRAIN
- done  out  1  test complete; held until next start or reset
- fail  out  1  sticky, any miscompare this run
- fail_elem  out  3  March element index (0..5) of first miscompare
- fail_addr  out  ADDR_WIDTH  address of first miscompare
- fail_data  out  DATA_WIDTH  rdata XOR expected at first miscompare
- fail_cnt  out  CNT_WIDTH  miscompare count, saturates at all-ones

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on start. DONE→RUN on start, clearing fail, fail_elem, fail_addr, fail_data, fail_cnt and done.
- RUN→DRAIN after the last op. DRAIN lasts 2 cycles, then DONE.
- start is ignored in RUN and DRAIN.
- Elements, one op per cycle:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ runs address 0→N-1; ⇓ runs N-1→0.
- Ops within an element complete at one address before the address steps.
- Element boundary: the next element starts at its first address on the following cycle, with no bubble.
- Total ops = 10N.
- wdata rule: in each cycle, wdata carries the data of the op issued in the next cycle. When that next op is a read, or there is no next op, wdata repeats its current value.
  - In IDLE and DONE, wdata = DATA_BG, so the first M0 write is correct.
- Outside RUN: write_read = 0, address = 0.
- Read check:
  - Expected value, element and address travel in a 2-stage pipeline alongside the op.
  - rdata is compared 2 cycles after the read op is driven.
  - Write ops push an invalid entry into the pipeline.
- Miscompare:
  - fail is set.
  - fail_cnt is incremented, saturating.
  - fail_elem, fail_addr and fail_data are captured only when fail was previously 0.
- Reset (rst_n = 0 at an edge):
  - State goes to IDLE and the pipeline is cleared.
  - Output values: busy=0, done=0, fail=0, fail_elem=0, fail_addr=0, fail_data=0, fail_cnt=0, write_read=0, address=0, wdata=DATA_BG.
  - Reset applied mid-run aborts the test; no partial done.

## Timing
- Cycle 0 is the cycle where start is sampled high; busy goes high in cycle 1.
- Op k (1-based) is driven in cycle k; ops occupy cycles 1..10N.
- A read driven in cycle c is checked at the end of cycle c+2; a fail it causes is visible in cycle c+3.
- DRAIN covers cycles 10N+1 and 10N+2.
- done=1 and busy=0 from cycle 10N+3.
- When start and rst_n=0 coincide, reset wins.

## Test plan
- Fault-free memory, N=16, DATA_BG=0 → cycles 1..16 are writes to addr 0..15 with data 0x00. Cycle 17 is a read of addr 0; cycle 18 writes 0xFF to addr 0; cycle 81 reads addr 15. done is asserted at cycle 163 with fail=0 and fail_cnt=0.
- Address 5 bit 2 stuck-at-0 → fail_elem=2, fail_addr=5, fail_data=0x04, fail_cnt=2 (M2 and M4 reads); done at cycle 163.
- Memory model with coupling fault active at address 7 → first miscompare is captured at addr 7; later miscompares increment fail_cnt without changing fail_addr.
- rst_n low at cycle 50 → all outputs at reset values by cycle 51 and no done. A new start runs the full 163-cycle sequence.
- Restart from DONE with start pulsed while busy (ignored) → results are cleared on restart and the sequence repeats identically. start pulses during RUN have no effect.
- Forced all-bits-wrong rdata, CNT_WIDTH=4 → fail_cnt saturates at 0xF.
